// File: rtl/cnn_img_loader_if.sv
// cnn_img_loader_if: pixel input stream and result output stream of the image loader
interface cnn_img_loader_if #(parameter int DATA_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  modport master (output in_valid, in_data, in_last, res_ready, input in_ready, res_valid, res_data);
  modport slave  (input in_valid, in_data, in_last, res_ready, output in_ready, res_valid, res_data);
endinterface

// File: rtl/cnn_img_loader.sv
// cnn_img_loader: assembles 64-word frames and sequences the CNN core reset/enable/result.
// Define CNN_IMG_LOADER_PINGPONG_EN for two alternating image buffers (default: one buffer).
module cnn_img_loader #(
  parameter int IMG_WORDS = 64,
  parameter int DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  cnn_img_loader_if.slave             io,
  output logic                        core_rst,
  output logic                        core_enable,
  output logic [DATA_W*IMG_WORDS-1:0] core_img,
  input  logic [DATA_W-1:0]           core_value,
  input  logic                        core_done,
  output logic                        frame_err,
  output logic                        busy
);
`ifdef CNN_IMG_LOADER_PINGPONG_EN
  localparam int   NB = 2;
  localparam logic PP = 1'b1;
`else
  localparam int   NB = 1;
  localparam logic PP = 1'b0;
`endif
  localparam int AW = $clog2(IMG_WORDS);
  typedef enum logic [1:0] {IDLE, CORE_RST, RUN, HOLD} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] buf_q [NB][IMG_WORDS];
  logic [DATA_W-1:0] buf_d [NB][IMG_WORDS];
  logic [NB-1:0]     full_q, full_d;
  logic              fill_sel_q, fill_sel_d, run_sel_q, run_sel_d;
  logic [AW-1:0]     wr_idx_q, wr_idx_d;
  logic              frame_err_q, frame_err_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              xfer, last_word;
  assign io.in_ready  = !rst && !full_q[fill_sel_q];
  assign xfer         = io.in_valid && io.in_ready;
  assign last_word    = wr_idx_q == AW'(IMG_WORDS - 1);
  assign io.res_valid = state_q == HOLD;
  assign io.res_data  = res_data_q;
  assign core_rst     = rst || state_q == CORE_RST;
  assign core_enable  = state_q == RUN;
  assign busy         = state_q != IDLE;
  assign frame_err    = frame_err_q;
  for (genvar i = 0; i < IMG_WORDS; i++) begin : g_img
    assign core_img[i*DATA_W +: DATA_W] = buf_q[run_sel_q][i];
  end
  always_comb begin
    buf_d       = buf_q;
    full_d      = full_q;
    fill_sel_d  = fill_sel_q;
    run_sel_d   = run_sel_q;
    wr_idx_d    = wr_idx_q;
    frame_err_d = frame_err_q;
    res_data_d  = res_data_q;
    state_d     = state_q;
    if (xfer) begin
      buf_d[fill_sel_q][wr_idx_q] = io.in_data;
      wr_idx_d    = (last_word || io.in_last) ? '0 : wr_idx_q + 1'b1;
      frame_err_d = frame_err_q | (last_word ^ io.in_last);
      if (last_word) begin
        full_d[fill_sel_q] = 1'b1;
        fill_sel_d         = fill_sel_q ^ PP;
      end
    end
    // a frame completing this very cycle starts the core without an extra IDLE cycle
    case (state_q)
      IDLE:     state_d = full_d[run_sel_q] ? CORE_RST : IDLE;
      CORE_RST: state_d = RUN;
      RUN: if (core_done) begin
        res_data_d        = core_value;
        full_d[run_sel_q] = 1'b0;
        run_sel_d         = run_sel_q ^ PP;
        state_d           = HOLD;
      end
      default:  state_d = io.res_ready ? IDLE : HOLD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_q       <= '{default: '0};
      full_q      <= '0;
      fill_sel_q  <= 1'b0;
      run_sel_q   <= 1'b0;
      wr_idx_q    <= '0;
      frame_err_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      full_q      <= full_d;
      fill_sel_q  <= fill_sel_d;
      run_sel_q   <= run_sel_d;
      wr_idx_q    <= wr_idx_d;
      frame_err_q <= frame_err_d;
      res_data_q  <= res_data_d;
    end
  end
endmodule

// File: doc/cnn_img_loader.md
# cnn_img_loader

Upstream feeder for the CNN core. Accepts an 8x8 image as a valid/ready stream of 32-bit words and assembles it into a flat 64-word buffer. It then resets and enables the core, waits for the core's sticky `done`, and returns the core's scalar result on a valid/ready output port. It owns the core's `rst`/`enable` sequencing, so the core restarts cleanly for every image.

## Interface
- `IMG_WORDS`, 64, words per image; the pointer is 6 bits wide
- `DATA_W`, 32, word width
- `clk` in 1: the only clock
- `rst` in 1: synchronous, active-high reset
- `in_valid` in 1: input word valid
- `in_ready` out 1: loader can accept a word
- `in_data` in DATA_W: pixel word, row-major
- `in_last` in 1: marks the final word of a frame
- `core_rst` out 1: core reset; equals `rst` OR (state == CORE_RST)
- `core_enable` out 1: core enable
- `core_img` out DATA_W*IMG_WORDS: word i occupies bits [i*DATA_W +: DATA_W]
- `core_value` in DATA_W: core result
- `core_done` in 1: core done (sticky until core reset)
- `res_valid` out 1: result valid
- `res_ready` in 1: result consumer ready
- `res_data` out DATA_W: captured result
- `frame_err` out 1: sticky framing error flag
- `busy` out 1: high whenever the state is not IDLE

## Operation
- Handshake: a word transfers on a rising edge when `in_valid && in_ready`. The word is written at index `wr_idx`, and `wr_idx` increments only on a transfer.
- Normal frame end: the transfer at `wr_idx == 63` marks the fill buffer full and resets `wr_idx` to 0.
- Early `in_last` (`in_last` on a transfer with `wr_idx < 63`):
  - the partial frame is discarded, `wr_idx` goes to 0, and `frame_err` is set;
  - the buffer is not marked full.
- Missing `in_last` on the word-63 transfer: the frame is still accepted and `frame_err` is set.
- `frame_err` clears only on `rst`.
- Core FSM states:
  - IDLE: go to CORE_RST when a full buffer exists.
  - CORE_RST: `core_rst` is 1 for exactly one cycle, then go to RUN. The run buffer is selected here and `core_img` is driven from it.
  - RUN: `core_enable` is 1. When `core_done` is sampled 1:
    - `core_value` is captured into `res_data`;
    - the run buffer is released (marked empty);
    - the FSM goes to HOLD.
  - HOLD: `core_enable` is 0 and `res_valid` is 1. On `res_ready`, go to IDLE.
- `core_img` stays stable from CORE_RST through RUN. Writes never target the run buffer.
- Frames are processed strictly in arrival order.

## Timing
- Reset values:
  - `in_ready` is 0 during `rst` and 1 in the first cycle after it.
  - `core_enable`, `res_valid`, `frame_err` and `busy` are 0.
  - `res_data` and `core_img` are 0.
  - `core_rst` is 1 while `rst` is high.
- `in_ready` depends only on registered state, never on `in_valid`.
- Word-63 transfer at edge N:
  - CORE_RST occupies cycle N+1;
  - `core_enable` is first high in cycle N+2.
- `core_done` sampled at edge M: `res_valid` rises and `core_enable` falls in cycle M+1.
- `res_valid`/`res_data` hold steady until `res_ready`. After the `res_ready` edge, the next CORE_RST can begin no earlier than one IDLE cycle later.
- `res_ready` while `res_valid` is 0 is ignored.
- A frame completing in the same cycle the FSM leaves HOLD is queued, not lost.
- `rst` asserted mid-fill or mid-RUN:
  - every buffer empties, `wr_idx` goes to 0, and the FSM goes to IDLE;
  - the core is held in reset;
  - no partial result is emitted.

## Configuration
- `CNN_IMG_LOADER_PINGPONG_EN` defined:
  - two image buffers; fill alternates between A and B;
  - `in_ready` is 1 whenever the current fill buffer is empty, so the next frame can load during RUN/HOLD of the previous one;
  - `in_ready` is 0 only when both buffers are full.
- Undefined:
  - single buffer;
  - `in_ready` goes 0 from the word-63 transfer until the buffer is released at `core_done` capture.

## Test plan
- Basic frame:
  - Stimulus: reset; stream words 0..63 with `in_last` on word 63; core model asserts `core_done` 10 cycles after enable with `core_value = 0x00001234`.
  - Required: one-cycle `core_rst` pulse; `core_img` word i == i; `res_data = 0x1234`; `frame_err = 0`.
- Result backpressure:
  - Stimulus: hold `res_ready` = 0 for 20 cycles after `res_valid`.
  - Required: `res_valid`/`res_data` stable; no new `core_rst`; `core_enable` = 0.
- Early last:
  - Stimulus: `in_last` on word 10; then send a correct frame of values 100..163.
  - Required: `frame_err = 1` and no core start for the bad frame; the correct frame runs with `core_img` word 0 == 100.
- Back-to-back frames:
  - Stimulus: stream two frames with no gap.
  - Required with the macro: `in_ready` stays 1 through the first run; frame 2's CORE_RST occurs 2 cycles after the `res_ready` of frame 1's result.
  - Required without the macro: `in_ready` = 0 from the first frame's word 63 until `core_done`.
- Reset mid-run:
  - Stimulus: `rst` for one cycle during RUN.
  - Required: all outputs at reset values; no `res_valid`; the next frame loads starting at index 0.
- Sparse input:
  - Stimulus: `in_valid` toggling every cycle with values 0..63.
  - Required: `core_img` word i == i; exactly one frame processed.
